memory_access_controller: RTL
=============================

Name: memory_access_controller

Overview:
Initiator-side controller that drives the single-port memory interface (addr, data_in, write_en, data_out) of the team's SRAM/DRAM/ROM memory block.
- Turns a client valid/ready request stream into correctly timed memory accesses and returns responses with backpressure.
- Includes a pipelined scan engine that reads every address and checks it against the ROM init pattern data[i] = i*3.
- Sits between a bus-side client and one memory instance.

Parameters:
MEMORY_TYPE, "SRAM", memory variant attached ("SRAM", "DRAM", "ROM"); "ROM" blocks all writes.
DATA_WIDTH, 8, memory word width.
ADDR_WIDTH, 4, memory address width; DEPTH = 1 << ADDR_WIDTH.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  client request valid
req_ready  output  1  controller can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  request address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  client accepts response
rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
rsp_error  output  1  write refused (ROM)
scan_start  input  1  start full-memory pattern scan
scan_busy  output  1  scan in progress
scan_done  output  1  one-cycle pulse at scan end
scan_errors  output  ADDR_WIDTH+1  mismatch count of last scan
mem_addr  output  ADDR_WIDTH  to memory addr
mem_data_in  output  DATA_WIDTH  to memory data_in
mem_write_en  output  1  to memory write_en
mem_data_out  input  DATA_WIDTH  from memory data_out (registered, 1-cycle read latency)

Behaviour:
- Reset (async, reset_n=0): all outputs 0 except req_ready, which is 1 after reset release; FSM returns to IDLE; scan counters cleared. Memory contents are not touched. Reset mid-access abandons that access; no response is produced.
- FSM states: IDLE, ACCESS, CAPTURE, RESP, SCAN, SCAN_DRAIN.
- IDLE: req_ready=1. If scan_start=1, go to SCAN. scan_start has priority over req_valid in the same cycle, and req_ready is 0 in that cycle. Otherwise, if req_valid=1, accept at edge E0: register mem_addr=req_addr and mem_data_in=req_wdata. Set mem_write_en=req_write, forced to 0 when MEMORY_TYPE=="ROM". Go to ACCESS.
- ACCESS: the memory samples at E1; mem_write_en returns to 0 after E1 (high exactly one cycle). Go to CAPTURE.
- CAPTURE: at E2, latch mem_data_out into rsp_rdata for reads, or 0 for writes. Set rsp_error=1 only for a ROM write. rsp_valid=1. Go to RESP.
  - Net latency: rsp_valid is high from the cycle after E2, i.e. 2 cycles after accept, for both reads and writes.
- RESP: hold rsp_valid, rsp_rdata and rsp_error stable while rsp_ready=0. On rsp_valid&&rsp_ready, clear all three and return to IDLE. req_ready=0 in every non-IDLE state.
- Read-during-write never occurs: one access is outstanding at a time. This keeps DRAM (data_out not updated on write cycles) and SRAM (old-data read) behaviour identical from the client's view.
- SCAN:
  - On entry, clear scan_errors and set scan_busy=1.
  - Issue mem_addr = 0..DEPTH-1, one per cycle, with mem_write_en=0.
  - Read data for address k is compared 2 cycles after it is issued, against expected(k) = (k*3) truncated to DATA_WIDTH.
  - Each mismatch increments scan_errors; it saturates at DEPTH.
  - After address DEPTH-1 is issued, go to SCAN_DRAIN for the 2 outstanding compares.
- SCAN_DRAIN: after the last compare, pulse scan_done=1 for one cycle, drop scan_busy and return to IDLE. Total: scan_done in cycle DEPTH+2 after the accepting edge.
  - scan_errors holds its value until the next scan_start.
- scan_start outside IDLE is ignored. The address counter wraps by natural width and must not issue address DEPTH.

Decomposition:
- Package mem_access_pkg holds:
  - state enum type;
  - memory-type string constants;
  - function expected_pattern(addr), returning (addr*3) truncated to DATA_WIDTH;
  - localparam helper for DEPTH.
- No sub-module. The 2-stage scan compare pipeline is small enough to stay inline.

Test Plan:
- reset_n=0 asserted during ACCESS of a read -> all outputs 0 immediately, req_ready=1 after release, no rsp_valid ever appears for that read.
- SRAM: write addr 5 data 0xA5, then read addr 5 -> mem_write_en high exactly 1 cycle, each rsp_valid 2 cycles after accept, read rsp_rdata=0xA5, rsp_error=0.
- ROM: write addr 3 data 0xFF -> rsp_error=1, mem_write_en never 1. Then read addr 3 -> rsp_rdata=0x09. Read addr 15 -> 0x2D.
- ROM: scan_start pulse -> scan_busy for 18 cycles, scan_done single pulse, scan_errors=0. req_valid during scan is not accepted.
- SRAM prefilled with i*3 except addr 10 = 0x00 -> scan_errors=1. Repeat on DRAM -> same result.
- Read addr 2 with rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Next request is accepted the cycle after the handshake.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types, constants and helpers for memory_access_controller
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESP,
        ST_SCAN,
        ST_SCAN_DRAIN
    } state_t;

    localparam string MEM_SRAM = "SRAM";
    localparam string MEM_DRAM = "DRAM";
    localparam string MEM_ROM  = "ROM";

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // ROM init pattern: word i holds i*3, truncated to the memory word width
    function automatic logic [31:0] expected_pattern(input int unsigned addr, input int unsigned width);
        logic [31:0] prod;
        prod = addr * 3;
        if (width >= 32) begin
            return prod;
        end
        return prod & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/memory_access_controller.sv
// rtl/memory_access_controller.sv - client request/response to single-port memory, plus pattern scan engine
module memory_access_controller
    import mem_access_pkg::*;
#(
    parameter string MEMORY_TYPE = "SRAM",
    parameter int    DATA_WIDTH  = 8,
    parameter int    ADDR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    input  logic                  scan_start,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic [ADDR_WIDTH:0]   scan_errors,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam int                    DEPTH     = depth_of(ADDR_WIDTH);
    localparam bit                    IS_ROM    = (MEMORY_TYPE == MEM_ROM);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state;
    state_t                  state_next;
    logic                    acc_write;
    logic                    cmp_valid;
    logic [ADDR_WIDTH-1:0]   cmp_addr;
    logic [DATA_WIDTH-1:0]   cmp_expected;

    assign req_ready    = reset_n && (state == ST_IDLE) && !scan_start;
    assign cmp_expected = DATA_WIDTH'(expected_pattern(32'(cmp_addr), DATA_WIDTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (scan_start) begin
                    state_next = ST_SCAN;
                end else if (req_valid) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS:     state_next = ST_CAPTURE;
            ST_CAPTURE:    state_next = ST_RESP;
            ST_RESP:       if (rsp_ready) state_next = ST_IDLE;
            ST_SCAN:       if (mem_addr == LAST_ADDR) state_next = ST_SCAN_DRAIN;
            ST_SCAN_DRAIN: if (!cmp_valid) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
            acc_write    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
            scan_busy    <= 1'b0;
            scan_done    <= 1'b0;
            scan_errors  <= '0;
            cmp_valid    <= 1'b0;
            cmp_addr     <= '0;
        end else begin
            scan_done <= 1'b0;
            // Stage 2 of the scan pipeline: the address issued last cycle has its data one cycle later
            cmp_valid <= (state == ST_SCAN);
            cmp_addr  <= mem_addr;
            case (state)
                ST_IDLE: begin
                    if (scan_start) begin
                        mem_addr     <= '0;
                        mem_write_en <= 1'b0;
                        scan_errors  <= '0;
                        scan_busy    <= 1'b1;
                    end else if (req_valid) begin
                        mem_addr     <= req_addr;
                        mem_data_in  <= req_wdata;
                        mem_write_en <= req_write && !IS_ROM;
                        acc_write    <= req_write;
                    end
                end
                ST_ACCESS: begin
                    mem_write_en <= 1'b0;
                end
                ST_CAPTURE: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= acc_write ? '0 : mem_data_out;
                    rsp_error <= acc_write && IS_ROM;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (mem_addr != LAST_ADDR) begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                    end
                end
                ST_SCAN_DRAIN: begin
                    if (!cmp_valid) begin
                        scan_done <= 1'b1;
                        scan_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (cmp_valid && (mem_data_out != cmp_expected) && (scan_errors != ERR_MAX)) begin
                scan_errors <= scan_errors + (ADDR_WIDTH + 1)'(1);
            end
        end
    end

endmodule
